// File: rtl/piso_shifter.sv
// Parallel-in serial-out shifter.
// Captures a WIDTH-bit word when idle and streams it MSB first on Q.
// A shift enable can pause a word in flight, and a one-cycle done pulse
// follows the last bit.
module piso_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             load,
  input  logic             enable,
  output logic             ready,
  output logic             busy,
  output logic             Q,
  output logic             not_Q,
  output logic             done
);

  // Counter just wide enough to hold WIDTH-1, which is the largest count it loads.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             q_reg, q_nxt;
  logic             busy_reg, busy_nxt;
  logic             done_reg, done_nxt;

  // State, data and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      q_reg    <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      cnt      <= cnt_nxt;
      q_reg    <= q_nxt;
      busy_reg <= busy_nxt;
      done_reg <= done_nxt;
    end
  end

  // Next-state logic.
  // Every register holds its value by default, so a paused SHIFT needs no extra code.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    q_nxt     = q_reg;
    busy_nxt  = busy_reg;
    done_nxt  = done_reg;

    case (state)
      IDLE: begin
        q_nxt    = 1'b0;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        if (load) begin
          shreg_nxt = D;
          q_nxt     = D[WIDTH-1];
          cnt_nxt   = CW'(WIDTH - 1);
          busy_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        if (enable) begin
          if (cnt == '0) begin
            state_nxt = DONE;
            q_nxt     = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
            q_nxt     = shreg[WIDTH-2];
            cnt_nxt   = cnt - CW'(1);
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
        q_nxt     = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
        q_nxt     = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
      end
    endcase
  end

  assign Q     = q_reg;
  assign not_Q = ~q_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign ready = (state == IDLE);

endmodule

// File: tb/tb_piso_shifter.sv
// Self-checking bench for piso_shifter at WIDTH=8.
// A vector table drives the plain and paused serializations.
// Hand-written sequences cover continuous load, async reset and a load made while disabled.
module tb_piso_shifter;

  logic       clk;
  logic       rst_n;
  logic [7:0] D;
  logic       load;
  logic       enable;
  logic       ready;
  logic       busy;
  logic       Q;
  logic       not_Q;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       load;
    logic       enable;
    logic [7:0] d;
    logic       q;
    logic       busy;
    logic       done;
    logic       ready;
  } vec_t;

  vec_t vecs[$];

  piso_shifter #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .D      (D),
    .load   (load),
    .enable (enable),
    .ready  (ready),
    .busy   (busy),
    .Q      (Q),
    .not_Q  (not_Q),
    .done   (done)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
    end
  endtask

  task automatic check_output(input string tag, input logic eq, input logic ebusy,
                              input logic edone, input logic eready);
    check_bit({tag, " Q"}, Q, eq);
    check_bit({tag, " not_Q"}, not_Q, ~eq);
    check_bit({tag, " busy"}, busy, ebusy);
    check_bit({tag, " done"}, done, edone);
    check_bit({tag, " ready"}, ready, eready);
  endtask

  // Drive inputs away from the edge, clock once, sample on the following falling edge.
  task automatic apply_stimulus(input logic l, input logic en, input logic [7:0] d);
    load   = l;
    enable = en;
    D      = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add_vec(input logic l, input logic en, input logic [7:0] d,
                         input logic eq, input logic ebusy, input logic edone,
                         input logic eready);
    vec_t v;
    v.load = l; v.enable = en; v.d = d;
    v.q = eq; v.busy = ebusy; v.done = edone; v.ready = eready;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] word;
    logic [7:0] dv;
    logic [7:0] w81;
    int         phase;

    load   = 1'b0;
    enable = 1'b0;
    D      = 8'h00;
    rst_n  = 1'b1;

    // 8'hA5 with enable high: bits 1,0,1,0,0,1,0,1, then done, then ready.
    // The D value after acceptance is junk and must not matter.
    add_vec(1, 1, 8'hA5, 1, 1, 0, 0);
    add_vec(0, 1, 8'hFF, 0, 1, 0, 0);
    add_vec(1, 1, 8'h00, 1, 1, 0, 0);
    add_vec(0, 1, 8'h3C, 0, 1, 0, 0);
    add_vec(0, 1, 8'hFF, 0, 1, 0, 0);
    add_vec(1, 1, 8'h00, 1, 1, 0, 0);
    add_vec(0, 1, 8'h77, 0, 1, 0, 0);
    add_vec(0, 1, 8'h00, 1, 1, 0, 0);
    add_vec(0, 1, 8'hFF, 0, 0, 1, 0);
    add_vec(0, 1, 8'hFF, 0, 0, 0, 1);
    // 8'hF0 with a three-cycle pause after the second bit.
    // A load attempt during the pause is ignored. Busy is high for 11 cycles.
    add_vec(1, 1, 8'hF0, 1, 1, 0, 0);
    add_vec(0, 1, 8'h00, 1, 1, 0, 0);
    add_vec(0, 0, 8'h00, 1, 1, 0, 0);
    add_vec(1, 0, 8'h00, 1, 1, 0, 0);
    add_vec(0, 0, 8'h0F, 1, 1, 0, 0);
    add_vec(0, 1, 8'h00, 1, 1, 0, 0);
    add_vec(0, 1, 8'h00, 1, 1, 0, 0);
    add_vec(0, 1, 8'h00, 0, 1, 0, 0);
    add_vec(0, 1, 8'hFF, 0, 1, 0, 0);
    add_vec(0, 1, 8'hFF, 0, 1, 0, 0);
    add_vec(0, 1, 8'h00, 0, 1, 0, 0);
    add_vec(0, 1, 8'h00, 0, 0, 1, 0);
    add_vec(0, 0, 8'h00, 0, 0, 0, 1);

    // Reset asserted between edges must take effect before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_output("async reset", 0, 0, 0, 1);
    @(negedge clk);
    check_output("reset held", 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle ignores enable and D when no load is requested.
    apply_stimulus(0, 1, 8'hFF);
    check_output("idle no load", 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].load, vecs[i].enable, vecs[i].d);
      check_output($sformatf("vec%0d", i), vecs[i].q, vecs[i].busy, vecs[i].done, vecs[i].ready);
    end

    // Load held high while D changes every cycle.
    // A word is accepted every 10 cycles and carries the D seen on its accept edge.
    word = 8'h00;
    for (int c = 0; c < 30; c++) begin
      dv    = 8'h5B + 8'(c * 8'h1D);
      phase = c % 10;
      if (phase == 0) word = dv;
      apply_stimulus(1, 1, dv);
      check_output($sformatf("stream c%0d", c),
                   (phase < 8) ? word[7 - phase] : 1'b0,
                   phase < 8, phase == 8, phase == 9);
    end

    // 8'hC3 is aborted by reset during its fourth bit (1,1,0,0,...).
    apply_stimulus(1, 1, 8'hC3);
    check_output("c3 bit1", 1, 1, 0, 0);
    apply_stimulus(0, 1, 8'h00);
    check_output("c3 bit2", 1, 1, 0, 0);
    apply_stimulus(0, 1, 8'h00);
    check_output("c3 bit3", 0, 1, 0, 0);
    apply_stimulus(0, 1, 8'h00);
    check_output("c3 bit4", 0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_output("abort reset", 0, 0, 0, 1);
    @(negedge clk);
    check_output("abort held", 0, 0, 0, 1);
    rst_n = 1'b1;

    // 8'h81 is loaded on the first edge after release with enable low.
    // The MSB must hold on Q until enable rises.
    w81 = 8'h81;
    apply_stimulus(1, 0, w81);
    check_output("81 load disabled", 1, 1, 0, 0);
    apply_stimulus(0, 0, 8'h00);
    check_output("81 hold", 1, 1, 0, 0);
    for (int b = 6; b >= 0; b--) begin
      apply_stimulus(0, 1, 8'hFF);
      check_output($sformatf("81 bit%0d", b), w81[b], 1, 0, 0);
    end
    apply_stimulus(0, 1, 8'h00);
    check_output("81 done", 0, 0, 1, 0);
    apply_stimulus(0, 1, 8'h00);
    check_output("81 idle", 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
